// File: rtl/hilo_muldiv_if.sv
// rtl/hilo_muldiv_if.sv - EX-stage issue/result bundle for the HI/LO multiply-divide unit
interface hilo_muldiv_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              flush;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              busy;
  logic              done;
  logic              dz;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, hi_i, lo_i,
    input  busy, done, dz, hi_o, lo_o
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, hi_i, lo_i,
    output busy, done, dz, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO pair with single-cycle multiplier and iterative restoring divider
// Defining HILO_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate ops (op 1xx).
module hilo_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic          clk,
  input logic          rst,
  hilo_muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state_q, state_d;

  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] a_mag_q, b_mag_q;
  logic              a_neg_q, b_neg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q, quo_q;
  logic              busy_q, done_q, dz_q;
`ifdef HILO_MADD_EN
  logic [2:0]        op_q;
`endif

  logic              op_legal, op_signed, op_div;
  logic [DATA_W-1:0] a_mag_d, b_mag_d;
  logic              accept, complete, div_zero, last_iter;

  logic [2*DATA_W-1:0] prod_mag, prod, mul_res;
  logic [DATA_W:0]     rem_shift, rem_diff;
  logic [DATA_W-1:0]   rem_next, quo_next, div_hi, div_lo;

  // Signed ops have op[0]==0; the operands are reduced to magnitudes on issue.
  always_comb begin
    op_signed = ~bus.op[0];
    op_div    = (bus.op[2:1] == 2'b01);
`ifdef HILO_MADD_EN
    op_legal  = 1'b1;
`else
    op_legal  = ~bus.op[2];
`endif
    a_mag_d   = (op_signed && bus.a[DATA_W-1]) ? -bus.a : bus.a;
    b_mag_d   = (op_signed && bus.b[DATA_W-1]) ? -bus.b : bus.b;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    complete  = 1'b0;
    div_zero  = (b_mag_q == '0);
    last_iter = (cnt_q == CNT_W'(DATA_W - 1));
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && op_legal) begin
            accept  = 1'b1;
            state_d = op_div ? DIV : MUL;
          end
        end
        MUL: begin
          complete = 1'b1;
          state_d  = IDLE;
        end
        DIV: begin
          if (div_zero || last_iter) begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    prod_mag = {{DATA_W{1'b0}}, a_mag_q} * {{DATA_W{1'b0}}, b_mag_q};
    prod     = (a_neg_q ^ b_neg_q) ? -prod_mag : prod_mag;
    mul_res  = prod;
`ifdef HILO_MADD_EN
    if (op_q[2]) mul_res = op_q[1] ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif
    // Restoring step: the borrow out of the (DATA_W+1)-bit subtract says "does not fit".
    rem_shift = {rem_q, quo_q[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, b_mag_q};
    if (!rem_diff[DATA_W]) begin
      rem_next = rem_diff[DATA_W-1:0];
      quo_next = {quo_q[DATA_W-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[DATA_W-1:0];
      quo_next = {quo_q[DATA_W-2:0], 1'b0};
    end
    div_lo = (a_neg_q ^ b_neg_q) ? -quo_next : quo_next;
    div_hi = a_neg_q ? -rem_next : rem_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q    <= '0;
      lo_q    <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef HILO_MADD_EN
      op_q    <= '0;
`endif
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= complete;
      dz_q   <= complete && (state_q == DIV) && div_zero;
      if (bus.hi_we) hi_q <= bus.hi_i;
      if (bus.lo_we) lo_q <= bus.lo_i;
      if (accept) begin
        a_mag_q <= a_mag_d;
        b_mag_q <= b_mag_d;
        a_neg_q <= op_signed && bus.a[DATA_W-1];
        b_neg_q <= op_signed && bus.b[DATA_W-1];
        cnt_q   <= '0;
        rem_q   <= '0;
        quo_q   <= a_mag_d;
`ifdef HILO_MADD_EN
        op_q    <= bus.op;
`endif
      end else if (state_q == DIV && !bus.flush && !complete) begin
        cnt_q <= cnt_q + CNT_W'(1);
        rem_q <= rem_next;
        quo_q <= quo_next;
      end
      // Operation results take priority over same-edge direct writes.
      if (complete) begin
        if (state_q == MUL) begin
          {hi_q, lo_q} <= mul_res;
        end else if (!div_zero) begin
          hi_q <= div_hi;
          lo_q <= div_lo;
        end
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - scoreboard bench for hilo_muldiv (MADD cases follow HILO_MADD_EN)
module tb_hilo_muldiv;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [64:0] sb[$];
  logic [31:0] m_hi, m_lo;

  hilo_muldiv_if #(.DATA_W(32)) bus ();

  hilo_muldiv #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {dz, hi, lo}.
  function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                        input logic [63:0] hl);
    logic signed [63:0] sx, sy, q, r, p;
    logic [63:0] ux, uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'b000: return {1'b0, sx * sy};
      3'b001: return {1'b0, ux * uy};
      3'b010, 3'b011: begin
        if (y == 32'd0) return {1'b1, hl};
        if (o[0]) begin q = ux / uy; r = ux % uy; end
        else begin q = sx / sy; r = sx % sy; end
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        p = o[0] ? ux * uy : sx * sy;
        return {1'b0, o[1] ? hl - p : hl + p};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sb_hi", bus.hi_o, e[63:32]);
        check("sb_lo", bus.lo_o, e[31:0]);
        check("sb_dz", bus.dz, e[64]);
      end
    end
  end

  task automatic drive_start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    n = 0;
    while (!bus.done && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", bus.done, 64'd1);
    @(negedge clk);
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.hi_i  = h;
    bus.lo_i  = l;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    m_hi = h;
    m_lo = l;
    check("wr_hi", bus.hi_o, h);
    check("wr_lo", bus.lo_o, l);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [64:0] e;
    e = model(o, x, y, {m_hi, m_lo});
    sb.push_back(e);
    m_hi = e[63:32];
    m_lo = e[31:0];
    drive_start(o, x, y);
    check("op_busy", bus.busy, 64'd1);
    wait_done(40);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd5; bus.flush = 1'b0;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.hi_i = 32'h1234; bus.lo_i = 32'h1234;
    repeat (3) @(negedge clk);
    check("rst_hi", bus.hi_o, 64'd0);
    check("rst_lo", bus.lo_o, 64'd0);
    check("rst_busy", bus.busy, 64'd0);
    check("rst_done", bus.done, 64'd0);
    check("rst_dz", bus.dz, 64'd0);
    rst = 1'b0; bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    check("post_rst_busy", bus.busy, 64'd0);

    // MULT then back-to-back MULTU issued in the done cycle
    sb.push_back({1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA});
    drive_start(3'b000, 32'hFFFFFFFE, 32'd3);
    check("mult_busy_e0", bus.busy, 64'd1);
    check("mult_done_e0", bus.done, 64'd0);
    @(negedge clk);
    check("mult_done_e1", bus.done, 64'd1);
    check("mult_busy_e1", bus.busy, 64'd0);
    sb.push_back({1'b0, 32'h00000002, 32'hFFFFFFFA});
    drive_start(3'b001, 32'hFFFFFFFE, 32'd3);
    check("b2b_busy", bus.busy, 64'd1);
    check("mult_done_pulse", bus.done, 64'd0);
    @(negedge clk);
    check("multu_done", bus.done, 64'd1);
    @(negedge clk);
    check("multu_done_clear", bus.done, 64'd0);
    m_hi = 32'h2; m_lo = 32'hFFFFFFFA;

    // DIV -7/2 with a stray start in busy cycle 5
    sb.push_back({1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
    drive_start(3'b010, 32'hFFFFFFF9, 32'd2);
    cycles = 0;
    for (int i = 0; i < 100 && bus.busy; i++) begin
      cycles++;
      bus.start = (cycles == 5);
      bus.op = 3'b001; bus.a = 32'd1; bus.b = 32'd1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("div_busy_cycles", cycles, 64'd32);
    check("div_done", bus.done, 64'd1);
    repeat (2) @(negedge clk);
    check("div_stray_start", bus.busy, 64'd0);
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFD;

    // Divide by zero keeps HI/LO
    write_hilo(32'hAA, 32'hBB);
    sb.push_back({1'b1, 32'hAA, 32'hBB});
    drive_start(3'b011, 32'd5, 32'd0);
    check("dz_busy", bus.busy, 64'd1);
    @(negedge clk);
    check("dz_done", bus.done, 64'd1);
    check("dz_pulse", bus.dz, 64'd1);
    check("dz_busy_clear", bus.busy, 64'd0);
    @(negedge clk);
    check("dz_pulse_clear", bus.dz, 64'd0);

    // Flush at iteration 10, then reissue
    drive_start(3'b011, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    check("flush_pre_busy", bus.busy, 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 64'd0);
    check("flush_done", bus.done, 64'd0);
    repeat (3) @(negedge clk);
    check("flush_hi", bus.hi_o, m_hi);
    check("flush_lo", bus.lo_o, m_lo);
    sb.push_back({1'b0, 32'd2, 32'd14});
    drive_start(3'b011, 32'd100, 32'd7);
    wait_done(40);
    m_hi = 32'd2; m_lo = 32'd14;

    // Flush beats start in the same cycle
    bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'd9; bus.b = 32'd9; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_vs_start", bus.busy, 64'd0);
    @(negedge clk);
    check("flush_vs_start_hi", bus.hi_o, m_hi);

    // Completion edge beats a direct write
    sb.push_back({1'b0, 32'd0, 32'd30});
    drive_start(3'b001, 32'd5, 32'd6);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.hi_i = 32'hDEAD; bus.lo_i = 32'hBEEF;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("prio_done", bus.done, 64'd1);
    m_hi = 32'd0; m_lo = 32'd30;
    @(negedge clk);

    // Signed divide corners and random traffic through the model
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF);
    run_op(3'b010, 32'd7, 32'hFFFFFFFE);
    run_op(3'b000, 32'h80000000, 32'h80000000);
    for (int i = 0; i < 6; i++) begin
      run_op(3'b000, $urandom, $urandom);
      run_op(3'b011, $urandom, $urandom_range(32'hFFFF, 1));
      run_op(3'b001, $urandom, $urandom);
    end

`ifdef HILO_MADD_EN
    write_hilo(32'd0, 32'hFFFFFFFF);
    sb.push_back({1'b0, 32'd1, 32'd0});
    m_hi = 32'd1; m_lo = 32'd0;
    drive_start(3'b101, 32'd1, 32'd1);
    wait_done(10);
    run_op(3'b110, 32'd2, 32'd3);
    run_op(3'b100, 32'hFFFFFFFF, 32'd5);
    run_op(3'b111, 32'h10000, 32'h10000);
`else
    write_hilo(32'd0, 32'hFFFFFFFF);
    drive_start(3'b101, 32'd1, 32'd1);
    check("madd_illegal_busy", bus.busy, 64'd0);
    repeat (3) @(negedge clk);
    check("madd_illegal_hi", bus.hi_o, 64'd0);
    check("madd_illegal_lo", bus.lo_o, 64'hFFFFFFFF);
`endif

    // Reset in the middle of a divide
    drive_start(3'b011, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1; bus.hi_we = 1'b1; bus.hi_i = 32'h55;
    @(negedge clk);
    rst = 1'b0; bus.hi_we = 1'b0;
    check("mid_rst_busy", bus.busy, 64'd0);
    check("mid_rst_hi", bus.hi_o, 64'd0);
    check("mid_rst_lo", bus.lo_o, 64'd0);
    repeat (40) @(negedge clk);
    check("mid_rst_idle", bus.busy, 64'd0);

    check("sb_empty", sb.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised HI/LO unit for the pipelined CPU. It holds the HI/LO register pair and integrates a single-pass multiplier and an iterative restoring divider. It also accepts direct MTHI/MTLO writes. The EX stage issues operations through a start/busy/done handshake and stalls on `busy`; WB reads `hi_o`/`lo_o`.

## Interface
Parameters:
- `DATA_W`, default 32: operand and HI/LO width; divider iteration count equals `DATA_W`.
- `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  issue the operation in `op` with `a`/`b`; accepted only in IDLE.
- `op`  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU
  - 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU (macro-dependent)
- `a`, `b`  in  DATA_W  operands; multiplicand/multiplier or dividend/divisor.
- `flush`  in  1  abort any in-flight operation.
- `hi_we`, `lo_we`  in  1  direct-write enables (MTHI/MTLO).
- `hi_i`, `lo_i`  in  DATA_W  direct-write data.
- `busy`  out  1  registered; high while an operation is in flight.
- `done`  out  1  registered one-cycle pulse after HI/LO are updated by an operation.
- `dz`  out  1  registered one-cycle pulse, coincident with `done`, for divide by zero.
- `hi_o`, `lo_o`  out  DATA_W  registered HI/LO.

## Operation
- FSM states: IDLE, MUL, DIV.
  - IDLE + `start` + legal `op` -> MUL (mult-class) or DIV (div-class).
  - Operands are latched on acceptance; signed ops latch magnitudes plus sign bits.
  - MUL -> IDLE after 1 cycle.
  - DIV -> IDLE after `DATA_W` iterations, or after 1 cycle if `b`==0.
- Multiply:
  - Full 2·DATA_W product, signed (MULT) or unsigned (MULTU).
  - {HI,LO} <= product.
- Divide, one restoring step per cycle on magnitudes:
  - Quotient is negated if operand signs differ; remainder takes the dividend's sign.
  - Result: LO = quotient, HI = remainder.
  - MIN/−1 yields LO = MIN, HI = 0; no trap.
- Divide by zero: HI/LO unchanged; `done` and `dz` pulse.
- Start rules:
  - `start` while busy is ignored.
  - Illegal `op` is ignored: no busy, no done.
- Flush:
  - `flush` returns the FSM to IDLE; HI/LO unchanged; no done.
  - `flush` beats `start` in the same cycle.
- Direct writes:
  - Applied at any edge, independently per register.
  - On the completion edge, the operation result wins for both registers.
- Reset:
  - HI=0, LO=0, FSM IDLE, `busy`=0, `done`=0, `dz`=0, counter=0, latched operands=0.
  - Reset overrides flush, start, and direct writes, including mid-divide.

## Timing
- Edge E0 accepts `start`; `busy`=1 from E0 until the completion edge.
- MUL: HI/LO written at E1; `busy`=0 and `done`=1 during cycle E1–E2.
- DIV, `b`≠0: HI/LO written at E`DATA_W`; `done` is high in the following cycle.
- DIV, `b`=0: completes at E1.
- Back-to-back issue: a new `start` can be accepted in the same cycle `done` is high.
- Accumulate ops read HI/LO at the completion edge, so a direct write at E0 is included.
- Arithmetic wraps modulo 2^(2·DATA_W).

## Configuration
- Macro `HILO_MADD_EN`.
- Defined: op 100–111 are legal and run through MUL in 1 cycle:
  - {HI,LO} <= {HI,LO} ± product.
  - Signed for MADD/MSUB, unsigned for MADDU/MSUBU.
- Undefined: op 1xx is illegal and ignored; the accumulate datapath is not synthesised.

## Test plan
- Reset: assert `rst` with `hi_we`=`lo_we`=1, `hi_i`=0x1234 -> `hi_o`=`lo_o`=0, `busy`=0, `done`=0.
- MULT a=0xFFFFFFFE, b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA at E1, `done` one cycle.
  - Repeat as MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (−7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - `busy` is high for exactly 32 cycles.
  - A `start` at cycle 5 is ignored.
- DIVU a=5, b=0 with HI=0xAA, LO=0xBB -> `done`=`dz`=1 at E1; HI/LO still 0xAA/0xBB.
- DIVU 100/7 flushed at iteration 10 -> `busy`=0 next cycle, no `done`, HI/LO unchanged.
  - Reissue DIVU 100/7 -> LO=14, HI=2.
- Macro defined: preset HI=0, LO=0xFFFFFFFF via direct write, then MADDU 1×1 -> HI=1, LO=0.
  - Macro undefined: the same `start` leaves `busy`=0, no `done`, HI/LO unchanged.
